// File: rtl/miriscv_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// miriscv_run_ctrl_if
// Bundle between a test harness and the miriscv run controller.
//   start_i      : one-cycle pulse that starts or restarts a run
//   rf_we_i      : snooped core register-file write enable
//   rf_waddr_i   : snooped core register-file write address
//   rf_wdata_i   : snooped core register-file write data
//   core_rst_n_o : active-low reset driven to the core
//   busy_o       : run sequence in progress (RESET or RUN)
//   done_o       : run ended by a write to the completion register
//   timeout_o    : run ended by exhausting the cycle budget
//   pass_o       : done_o with a non-zero captured result
//   result_o     : last value written to the result register
//   cycles_o     : RUN cycles elapsed
// Modports: master = harness side, slave = run controller side.
// ---------------------------------------------------------------------------
interface miriscv_run_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 16
);
  logic                 start_i;
  logic                 rf_we_i;
  logic [RF_ADDR_W-1:0] rf_waddr_i;
  logic [XLEN-1:0]      rf_wdata_i;
  logic                 core_rst_n_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 timeout_o;
  logic                 pass_o;
  logic [XLEN-1:0]      result_o;
  logic [CNT_W-1:0]     cycles_o;

  modport master (
    output start_i, rf_we_i, rf_waddr_i, rf_wdata_i,
    input  core_rst_n_o, busy_o, done_o, timeout_o, pass_o, result_o, cycles_o
  );

  modport slave (
    input  start_i, rf_we_i, rf_waddr_i, rf_wdata_i,
    output core_rst_n_o, busy_o, done_o, timeout_o, pass_o, result_o, cycles_o
  );
endinterface

// File: rtl/miriscv_run_ctrl.sv
// ---------------------------------------------------------------------------
// miriscv_run_ctrl
// Run controller for miriscv_top builds: holds the core in reset for
// RST_CYCLES after a start pulse, then lets it run for at most MAX_CYCLES.
// The register-file write port is snooped: writes to RESULT_REG are captured
// into result_o, a write to DONE_REG ends the run with done_o. If the budget
// runs out first, timeout_o is raised instead. The core is frozen (held in
// reset) once the run ends, so result_o and cycles_o stay stable.
// Ports:
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset
//   bus     : miriscv_run_ctrl_if slave (start, rf snoop, status outputs)
// ---------------------------------------------------------------------------
module miriscv_run_ctrl #(
  parameter int XLEN       = 32,
  parameter int RF_ADDR_W  = 5,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 300,
  parameter int RESULT_REG = 4,
  parameter int DONE_REG   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  miriscv_run_ctrl_if.slave      bus
);

  localparam int RCNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  // The cycle counter must be able to reach MAX_CYCLES-1 without wrapping.
  if (MAX_CYCLES > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("miriscv_run_ctrl: CNT_W too small for MAX_CYCLES");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;

  logic                result_hit_s;
  logic                done_hit_s;
  logic                waddr_nz_s;

  // x0 is hardwired zero, so a write addressed to it is never a real event,
  // even if RESULT_REG or DONE_REG is configured as 0.
  assign waddr_nz_s   = (bus.rf_waddr_i != {RF_ADDR_W{1'b0}});
  assign result_hit_s = bus.rf_we_i && waddr_nz_s &&
                        (bus.rf_waddr_i == RF_ADDR_W'(RESULT_REG));
  assign done_hit_s   = bus.rf_we_i && waddr_nz_s &&
                        (bus.rf_waddr_i == RF_ADDR_W'(DONE_REG));

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= {RCNT_W{1'b0}};
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      result_q     <= {XLEN{1'b0}};
      cycles_q     <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      result_q     <= result_d;
      cycles_q     <= cycles_d;
    end
  end

  // Next-state and next-status logic; status flips on the same edge as state.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    result_d     = result_q;
    cycles_d     = cycles_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        core_rst_n_d = 1'b0;
        if (bus.start_i) begin
          state_d   = ST_RESET;
          rst_cnt_d = RCNT_W'(RST_CYCLES);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          result_d  = {XLEN{1'b0}};
          cycles_d  = {CNT_W{1'b0}};
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_RESET: begin
        busy_d = 1'b1;
        // Counter holds the remaining reset cycles including this one.
        if (rst_cnt_q <= RCNT_W'(1)) begin
          state_d      = ST_RUN;
          core_rst_n_d = 1'b1;
          rst_cnt_d    = {RCNT_W{1'b0}};
        end else begin
          core_rst_n_d = 1'b0;
          rst_cnt_d    = rst_cnt_q - RCNT_W'(1);
        end
      end

      ST_RUN: begin
        if (result_hit_s) begin
          result_d = bus.rf_wdata_i;
        end else begin
          result_d = result_q;
        end
        // Completion write is checked first so it wins on the last budget cycle.
        if (done_hit_s) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          core_rst_n_d = 1'b0;
        end else if (cycles_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d      = ST_TIMEOUT;
          timeout_d    = 1'b1;
          busy_d       = 1'b0;
          core_rst_n_d = 1'b0;
        end else begin
          cycles_d     = cycles_q + CNT_W'(1);
          busy_d       = 1'b1;
          core_rst_n_d = 1'b1;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        rst_cnt_d    = {RCNT_W{1'b0}};
        core_rst_n_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        result_d     = {XLEN{1'b0}};
        cycles_d     = {CNT_W{1'b0}};
      end
    endcase
  end

  assign bus.core_rst_n_o = core_rst_n_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.result_o     = result_q;
  assign bus.cycles_o     = cycles_q;
  assign bus.pass_o       = done_q && (result_q != {XLEN{1'b0}});

endmodule

// File: tb/tb_miriscv_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_miriscv_run_ctrl
// Directed bench for miriscv_run_ctrl with default parameters
// (RST_CYCLES=2, MAX_CYCLES=300, RESULT_REG=4, DONE_REG=5).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_miriscv_run_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  miriscv_run_ctrl_if #(.XLEN(32), .RF_ADDR_W(5), .CNT_W(16)) bus ();

  miriscv_run_ctrl #(
    .XLEN(32), .RF_ADDR_W(5), .CNT_W(16), .RST_CYCLES(2),
    .MAX_CYCLES(300), .RESULT_REG(4), .DONE_REG(5)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One register-file write consumed by the next rising edge.
  task automatic rf_write(input logic [4:0] addr, input logic [31:0] data);
    bus.rf_we_i    = 1'b1;
    bus.rf_waddr_i = addr;
    bus.rf_wdata_i = data;
    tick();
    bus.rf_we_i    = 1'b0;
    bus.rf_waddr_i = 5'd0;
    bus.rf_wdata_i = 32'd0;
  endtask

  // Advance until cycles_o reads n, bounded.
  task automatic run_to(input int n, input string tag);
    for (int i = 0; i < 400 && bus.cycles_o != 16'(n); i++) tick();
    check(tag, 64'(bus.cycles_o), 64'(n));
  endtask

  // Pulse start, wait through the two RESET cycles, land on run cycle 0.
  task automatic start_run(input string tag);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    check({tag, "_core_rst_n"}, 64'(bus.core_rst_n_o), 64'd1);
    check({tag, "_cycles0"}, 64'(bus.cycles_o), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.rf_we_i    = 1'b0;
    bus.rf_waddr_i = 5'd0;
    bus.rf_wdata_i = 32'd0;
    tick();
    tick();

    // Reset state
    check("rst_core_rst_n", 64'(bus.core_rst_n_o), 64'd0);
    check("rst_busy",       64'(bus.busy_o),       64'd0);
    check("rst_done",       64'(bus.done_o),       64'd0);
    check("rst_timeout",    64'(bus.timeout_o),    64'd0);
    check("rst_result",     64'(bus.result_o),     64'd0);
    check("rst_cycles",     64'(bus.cycles_o),     64'd0);
    check("rst_pass",       64'(bus.pass_o),       64'd0);

    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(bus.busy_o), 64'd0);

    // Start: core reset held low exactly two cycles; writes and start ignored in RESET
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("reset1_core_rst_n", 64'(bus.core_rst_n_o), 64'd0);
    check("reset1_busy",       64'(bus.busy_o),       64'd1);
    bus.start_i    = 1'b1;
    bus.rf_we_i    = 1'b1;
    bus.rf_waddr_i = 5'd4;
    bus.rf_wdata_i = 32'hDEAD;
    tick();
    bus.start_i = 1'b0;
    bus.rf_we_i = 1'b0;
    check("reset2_core_rst_n", 64'(bus.core_rst_n_o), 64'd0);
    tick();
    check("run0_core_rst_n", 64'(bus.core_rst_n_o), 64'd1);
    check("run0_cycles",     64'(bus.cycles_o),     64'd0);
    check("run0_result",     64'(bus.result_o),     64'd0);
    check("run0_done",       64'(bus.done_o),       64'd0);
    check("run0_timeout",    64'(bus.timeout_o),    64'd0);

    // start during RUN has no effect
    run_to(10, "run_to10");
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("run_start_cycles", 64'(bus.cycles_o), 64'd11);
    check("run_start_busy",   64'(bus.busy_o),   64'd1);

    // write to x0 never captured
    run_to(50, "run_to50");
    rf_write(5'd0, 32'd5);
    check("x0_result", 64'(bus.result_o), 64'd0);

    // Prime program: x4=1 at cycle 120, x5 at cycle 125
    run_to(120, "run_to120");
    rf_write(5'd4, 32'd1);
    check("prime_result_cap", 64'(bus.result_o), 64'd1);
    check("prime_cycles121",  64'(bus.cycles_o), 64'd121);
    run_to(125, "run_to125");
    rf_write(5'd5, 32'd1);
    check("prime_done",       64'(bus.done_o),       64'd1);
    check("prime_timeout",    64'(bus.timeout_o),    64'd0);
    check("prime_result",     64'(bus.result_o),     64'd1);
    check("prime_pass",       64'(bus.pass_o),       64'd1);
    check("prime_cycles",     64'(bus.cycles_o),     64'd125);
    check("prime_core_rst_n", 64'(bus.core_rst_n_o), 64'd0);
    check("prime_busy",       64'(bus.busy_o),       64'd0);
    rf_write(5'd4, 32'd0);
    tick();
    check("done_hold_result", 64'(bus.result_o), 64'd1);
    check("done_hold_cycles", 64'(bus.cycles_o), 64'd125);
    check("done_hold_done",   64'(bus.done_o),   64'd1);

    // Restart from DONE clears status
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("restart_done",    64'(bus.done_o),   64'd0);
    check("restart_result",  64'(bus.result_o), 64'd0);
    check("restart_cycles",  64'(bus.cycles_o), 64'd0);
    check("restart_busy",    64'(bus.busy_o),   64'd1);
    check("restart_pass",    64'(bus.pass_o),   64'd0);
    tick();
    tick();
    check("restart_run_core_rst_n", 64'(bus.core_rst_n_o), 64'd1);

    // Non-prime: x4=7 then x4=0, then x5
    run_to(2, "np_run_to2");
    rf_write(5'd4, 32'd7);
    check("np_result7", 64'(bus.result_o), 64'd7);
    rf_write(5'd4, 32'd0);
    check("np_result0", 64'(bus.result_o), 64'd0);
    rf_write(5'd5, 32'd1);
    check("np_done",   64'(bus.done_o),   64'd1);
    check("np_pass",   64'(bus.pass_o),   64'd0);
    check("np_result", 64'(bus.result_o), 64'd0);
    check("np_cycles", 64'(bus.cycles_o), 64'd4);

    // Timeout: no x5 write
    start_run("to");
    run_to(5, "to_run_to5");
    rf_write(5'd4, 32'd9);
    check("to_result9", 64'(bus.result_o), 64'd9);
    run_to(299, "to_run_to299");
    check("to_pre_timeout", 64'(bus.timeout_o), 64'd0);
    tick();
    check("to_timeout",    64'(bus.timeout_o),    64'd1);
    check("to_done",       64'(bus.done_o),       64'd0);
    check("to_cycles",     64'(bus.cycles_o),     64'd299);
    check("to_pass",       64'(bus.pass_o),       64'd0);
    check("to_busy",       64'(bus.busy_o),       64'd0);
    check("to_core_rst_n", 64'(bus.core_rst_n_o), 64'd0);
    rf_write(5'd4, 32'd3);
    check("to_result_hold", 64'(bus.result_o), 64'd9);
    check("to_cycles_hold", 64'(bus.cycles_o), 64'd299);

    // Boundary: x5 write on the final budget cycle wins
    start_run("bd");
    run_to(299, "bd_run_to299");
    rf_write(5'd5, 32'd1);
    check("bd_done",    64'(bus.done_o),    64'd1);
    check("bd_timeout", 64'(bus.timeout_o), 64'd0);
    check("bd_cycles",  64'(bus.cycles_o),  64'd299);
    check("bd_pass",    64'(bus.pass_o),    64'd0);

    // Reset mid-run aborts everything
    start_run("mr");
    run_to(10, "mr_run_to10");
    rf_write(5'd4, 32'd6);
    check("mr_result6", 64'(bus.result_o), 64'd6);
    run_to(20, "mr_run_to20");
    rst_n = 1'b0;
    tick();
    check("mr_core_rst_n", 64'(bus.core_rst_n_o), 64'd0);
    check("mr_busy",       64'(bus.busy_o),       64'd0);
    check("mr_done",       64'(bus.done_o),       64'd0);
    check("mr_timeout",    64'(bus.timeout_o),    64'd0);
    check("mr_result",     64'(bus.result_o),     64'd0);
    check("mr_cycles",     64'(bus.cycles_o),     64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("mr_idle_busy",   64'(bus.busy_o),   64'd0);
    check("mr_idle_cycles", 64'(bus.cycles_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
